// File: rtl/stack_pkg.sv
// Shared definitions for the stack processor's operand stack, control and ALU.
package stack_pkg;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } stack_op_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/reg_file_n.sv
// Storage array: one synchronous write port, three combinational read ports.
module reg_file_n #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [PTR_W-1:0] w_addr,
  input  logic [WIDTH-1:0] w_data,
  input  logic [PTR_W-1:0] tos_addr,
  input  logic [PTR_W-1:0] nos_addr,
  input  logic [PTR_W-1:0] peek_addr,
  output logic [WIDTH-1:0] tos_data,
  output logic [WIDTH-1:0] nos_data,
  output logic [WIDTH-1:0] peek_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[w_addr] <= w_data;
    end
  end

  assign tos_data  = mem[tos_addr];
  assign nos_data  = mem[nos_addr];
  assign peek_data = mem[peek_addr];

endmodule

// File: rtl/reg_stack_n.sv
// Operand stack: pointer, sticky error flags and count-based read masking
// wrapped around reg_file_n.
module reg_stack_n
  import stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] w_data,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  input  logic [PTR_W-1:0] peek_addr,
  output logic [WIDTH-1:0] peek_data,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow,
  input  logic             clear_err
);

  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_TWO  = (PTR_W+1)'(2);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] IDX_ONE  = PTR_W'(1);

  stack_op_t        op;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W-1:0] cnt_lo, top_idx, nos_idx, peek_idx, w_addr;
  logic             we, ovf_set, unf_set, peek_ok;
  logic [WIDTH-1:0] tos_raw, nos_raw, peek_raw;

  assign op     = stack_op_t'({push, pop});
  assign full   = (count_q == CNT_FULL);
  assign empty  = (count_q == '0);
  assign count  = count_q;

  // Low bits of count wrap to 0 when full, so count-1 still lands on the top.
  assign cnt_lo   = count_q[PTR_W-1:0];
  assign top_idx  = cnt_lo - IDX_ONE;
  assign nos_idx  = top_idx - IDX_ONE;
  assign peek_idx = top_idx - peek_addr;
  assign peek_ok  = ({1'b0, peek_addr} < count_q);

  always_comb begin
    count_d = count_q;
    we      = 1'b0;
    w_addr  = top_idx;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (op)
      OP_PUSH: begin
        if (full) begin
          ovf_set = 1'b1;
        end else begin
          we      = 1'b1;
          w_addr  = cnt_lo;
          count_d = count_q + CNT_ONE;
        end
      end
      OP_POP: begin
        if (empty) unf_set = 1'b1;
        else       count_d = count_q - CNT_ONE;
      end
      OP_REPLACE: begin
        we = 1'b1;
        if (empty) begin
          w_addr  = '0;
          count_d = CNT_ONE;
          unf_set = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count_q <= count_d;
      // A new error in the same cycle as clear_err leaves the flag set.
      if (ovf_set)        overflow <= 1'b1;
      else if (clear_err) overflow <= 1'b0;
      if (unf_set)        underflow <= 1'b1;
      else if (clear_err) underflow <= 1'b0;
    end
  end

  reg_file_n #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) u_file (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .tos_addr  (top_idx),
    .nos_addr  (nos_idx),
    .peek_addr (peek_idx),
    .tos_data  (tos_raw),
    .nos_data  (nos_raw),
    .peek_data (peek_raw)
  );

  assign tos       = empty ? '0 : tos_raw;
  assign nos       = (count_q < CNT_TWO) ? '0 : nos_raw;
  assign peek_data = peek_ok ? peek_raw : '0;

endmodule

// File: tb/tb_reg_stack_n.sv
// Scoreboard bench for reg_stack_n: a 16x4 instance and an 8x8 instance.
module tb_reg_stack_n;

  logic        clk = 1'b0;
  logic        reset;

  logic        push, pop, clear_err;
  logic [15:0] w_data;
  logic [1:0]  peek_addr;
  logic [15:0] tos, nos, peek_data;
  logic [2:0]  count;
  logic        full, empty, overflow, underflow;

  logic        push8, pop8, clr8;
  logic [7:0]  w8;
  logic [2:0]  peek8;
  logic [7:0]  tos8, nos8, pk8;
  logic [3:0]  count8;
  logic        full8, empty8, ovf8, unf8;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    bit          is8;
    logic [15:0] tos, nos, peek;
    int          cnt;
    bit          full, empty, ovf, unf;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;

  always #5 clk = ~clk;

  reg_stack_n #(.WIDTH(16), .DEPTH(4)) u_dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .w_data(w_data),
    .tos(tos), .nos(nos), .peek_addr(peek_addr), .peek_data(peek_data),
    .count(count), .full(full), .empty(empty), .overflow(overflow),
    .underflow(underflow), .clear_err(clear_err)
  );

  reg_stack_n #(.WIDTH(8), .DEPTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .push(push8), .pop(pop8), .w_data(w8),
    .tos(tos8), .nos(nos8), .peek_addr(peek8), .peek_data(pk8),
    .count(count8), .full(full8), .empty(empty8), .overflow(ovf8),
    .underflow(unf8), .clear_err(clr8)
  );

  task automatic chk(string nm, string field, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s %s actual=%0h expected=%0h", nm, field, act, exp);
    end
  endtask

  // Monitor: drains every expectation queued for the current sample point.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.is8) begin
          chk(e.name, "tos",       int'(tos8),   int'(e.tos));
          chk(e.name, "nos",       int'(nos8),   int'(e.nos));
          chk(e.name, "peek",      int'(pk8),    int'(e.peek));
          chk(e.name, "count",     int'(count8), e.cnt);
          chk(e.name, "full",      int'(full8),  int'(e.full));
          chk(e.name, "empty",     int'(empty8), int'(e.empty));
          chk(e.name, "overflow",  int'(ovf8),   int'(e.ovf));
          chk(e.name, "underflow", int'(unf8),   int'(e.unf));
        end else begin
          chk(e.name, "tos",       int'(tos),       int'(e.tos));
          chk(e.name, "nos",       int'(nos),       int'(e.nos));
          chk(e.name, "peek",      int'(peek_data), int'(e.peek));
          chk(e.name, "count",     int'(count),     e.cnt);
          chk(e.name, "full",      int'(full),      int'(e.full));
          chk(e.name, "empty",     int'(empty),     int'(e.empty));
          chk(e.name, "overflow",  int'(overflow),  int'(e.ovf));
          chk(e.name, "underflow", int'(underflow), int'(e.unf));
        end
      end
    end
  end

  task automatic expect_state(string nm, bit is8, int t, int n, int p, int c, bit o, bit u);
    exp_t e;
    e.name  = nm;
    e.is8   = is8;
    e.tos   = 16'(t);
    e.nos   = 16'(n);
    e.peek  = 16'(p);
    e.cnt   = c;
    e.full  = (c == (is8 ? 8 : 4));
    e.empty = (c == 0);
    e.ovf   = o;
    e.unf   = u;
    exp_q.push_back(e);
    -> sample_ev;
  endtask

  task automatic step4(string nm, bit pu, bit po, int d, int pa, bit clr,
                       int t, int n, int p, int c, bit o, bit u);
    @(negedge clk);
    push = pu; pop = po; w_data = 16'(d); peek_addr = 2'(pa); clear_err = clr;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clear_err = 1'b0;
    expect_state(nm, 1'b0, t, n, p, c, o, u);
  endtask

  task automatic step8(string nm, bit pu, bit po, int d, bit clr,
                       int t, int n, int p, int c, bit o, bit u);
    @(negedge clk);
    push8 = pu; pop8 = po; w8 = 8'(d); clr8 = clr;
    @(posedge clk);
    #1;
    push8 = 1'b0; pop8 = 1'b0; clr8 = 1'b0;
    expect_state(nm, 1'b1, t, n, p, c, o, u);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset = 1'b1;
    push = 0; pop = 0; clear_err = 0; w_data = '0; peek_addr = '0;
    push8 = 0; pop8 = 0; clr8 = 0; w8 = '0; peek8 = 3'd7;
    #2;
    expect_state("reset", 1'b0, 0, 0, 0, 0, 0, 0);
    expect_state("reset8", 1'b1, 0, 0, 0, 0, 0, 0);
    #10 reset = 1'b0;

    // fill to full, then peek the bottom
    step4("push10", 1, 0, 10, 0, 0, 10,  0, 10, 1, 0, 0);
    step4("push20", 1, 0, 20, 0, 0, 20, 10, 20, 2, 0, 0);
    step4("push30", 1, 0, 30, 0, 0, 30, 20, 30, 3, 0, 0);
    step4("push40", 1, 0, 40, 0, 0, 40, 30, 40, 4, 0, 0);
    step4("peek3",  0, 0,  0, 3, 0, 40, 30, 10, 4, 0, 0);

    // overflow, clear, and clear coinciding with a new overflow
    step4("push_full",   1, 0, 50, 3, 0, 40, 30, 10, 4, 1, 0);
    step4("clr_ovf",     0, 0,  0, 3, 1, 40, 30, 10, 4, 0, 0);
    step4("push_full_clr", 1, 0, 51, 3, 1, 40, 30, 10, 4, 1, 0);
    step4("clr_ovf2",    0, 0,  0, 3, 1, 40, 30, 10, 4, 0, 0);

    // drain and underflow
    step4("pop1", 0, 1, 0, 0, 0, 30, 20, 30, 3, 0, 0);
    step4("pop2", 0, 1, 0, 0, 0, 20, 10, 20, 2, 0, 0);
    step4("pop3", 0, 1, 0, 0, 0, 10,  0, 10, 1, 0, 0);
    step4("pop4", 0, 1, 0, 0, 0,  0,  0,  0, 0, 0, 0);
    step4("pop_empty", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step4("clr_unf",   0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // replace
    step4("push7",      1, 0,  7, 0, 0,  7, 0,  7, 1, 0, 0);
    step4("replace99",  1, 1, 99, 0, 0, 99, 0, 99, 1, 0, 0);
    step4("pop_r",      0, 1,  0, 0, 0,  0, 0,  0, 0, 0, 0);
    step4("replace_empty", 1, 1, 5, 0, 0, 5, 0, 5, 1, 0, 1);
    step4("clr_unf2",   0, 0,  0, 0, 1,  5, 0,  5, 1, 0, 0);
    step4("push6",      1, 0,  6, 0, 0,  6, 5,  6, 2, 0, 0);
    step4("push7b",     1, 0,  7, 0, 0,  7, 6,  7, 3, 0, 0);
    step4("push8",      1, 0,  8, 0, 0,  8, 7,  8, 4, 0, 0);
    step4("replace_full", 1, 1, 77, 0, 0, 77, 7, 77, 4, 0, 0);
    step4("peek_bottom", 0, 0,  0, 3, 0, 77, 7,  5, 4, 0, 0);

    // asynchronous reset between clock edges
    @(negedge clk);
    reset = 1'b1;
    #1;
    expect_state("sync_rst", 1'b0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step4("push1", 1, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0);
    step4("push2", 1, 0, 2, 0, 0, 2, 1, 2, 2, 0, 0);
    step4("push3", 1, 0, 3, 0, 0, 3, 2, 3, 3, 0, 0);
    step4("push4", 1, 0, 4, 0, 0, 4, 3, 4, 4, 0, 0);
    step4("push5_ovf", 1, 0, 5, 0, 0, 4, 3, 4, 4, 1, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 expect_state("async_rst", 1'b0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    step4("push9",   1, 0, 9, 2, 0, 9, 0, 0, 1, 0, 0);
    step4("peek1_c1", 0, 0, 0, 1, 0, 9, 0, 0, 1, 0, 0);
    step4("peek3_c1", 0, 0, 0, 3, 0, 9, 0, 0, 1, 0, 0);
    step4("peek0_c1", 0, 0, 0, 0, 0, 9, 0, 9, 1, 0, 0);

    // 8x8 instance: LIFO order and count tracking
    for (int i = 1; i <= 8; i++)
      step8("p8_push", 1, 0, 256 - i, 0, 256 - i, (i >= 2) ? 257 - i : 0,
            (i == 8) ? 'hFF : 0, i, 0, 0);
    step8("p8_ovf", 1, 0, 'h11, 0, 'hF8, 'hF9, 'hFF, 8, 1, 0);
    step8("p8_clr", 0, 0, 0, 1, 'hF8, 'hF9, 'hFF, 8, 0, 0);
    for (int j = 1; j <= 8; j++) begin
      c = 8 - j;
      step8("p8_pop", 0, 1, 0, 0, (c > 0) ? 256 - c : 0, (c >= 2) ? 257 - c : 0,
            0, c, 0, 0);
    end
    step8("p8_unf", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);

    #20;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
